// File: rtl/tlc_pkg.sv
// Shared types and default timings for the traffic-light phase scheduler.
package tlc_pkg;

    // Light codes driven on TL_main / TL_side / TL_turn (code 3 is never used).
    typedef enum logic [1:0] {
        LIGHT_GREEN  = 2'd0,
        LIGHT_YELLOW = 2'd1,
        LIGHT_RED    = 2'd2
    } light_t;

    // Active phase codes driven on the phase output.
    typedef enum logic [1:0] {
        PHASE_MAIN = 2'd0,
        PHASE_SIDE = 2'd1,
        PHASE_TURN = 2'd2,
        PHASE_PED  = 2'd3
    } phase_t;

    // Controller states; GREEN and YELLOW apply to whichever approach phase selects.
    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_WALK   = 2'd3
    } state_t;

    // Tick timer width; the timer saturates at its all-ones value.
    localparam int TIMER_W = 6;
    // Durations are compared one bit wider than the timer so timer+1 never wraps.
    localparam int LEN_W   = TIMER_W + 1;

    // Default durations, in ticks.
    localparam int DEF_G_MAIN_PEAK = 32;
    localparam int DEF_G_MAIN_OFF  = 16;
    localparam int DEF_G_SIDE_PEAK = 32;
    localparam int DEF_G_SIDE_OFF  = 16;
    localparam int DEF_G_TURN_PEAK = 16;
    localparam int DEF_G_TURN_OFF  = 8;
    localparam int DEF_Y_TIME      = 4;
    localparam int DEF_AR_TIME     = 2;
    localparam int DEF_WALK_TIME   = 8;

    // True when the tick arriving now completes an interval of len ticks.
    function automatic logic interval_done(input logic [TIMER_W-1:0] count,
                                           input logic [LEN_W-1:0]   len);
        return ({1'b0, count} + LEN_W'(1)) == len;
    endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Control inputs and light outputs of the phase scheduler, grouped as one bus.
interface tlc_phase_scheduler_if;

    logic       tick;
    logic       peak;
    logic       sensor1;
    logic       sensor2;
    logic       ped_req;
    logic [1:0] TL_main;
    logic [1:0] TL_side;
    logic [1:0] TL_turn;
    logic       ped_walk;
    logic [1:0] phase;

    // Environment side: drives timing/demand, observes the lights.
    modport master (
        output tick, peak, sensor1, sensor2, ped_req,
        input  TL_main, TL_side, TL_turn, ped_walk, phase
    );

    // Controller side.
    modport slave (
        input  tick, peak, sensor1, sensor2, ped_req,
        output TL_main, TL_side, TL_turn, ped_walk, phase
    );

endinterface

// File: rtl/tlc_tick_timer.sv
// Saturating tick counter: clears on request, advances only on tick.
module tlc_tick_timer
    import tlc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               tick,
    output logic [TIMER_W-1:0] count
);

    localparam logic [TIMER_W-1:0] COUNT_MAX = '1;

    // Count ticks spent in the current interval; clear has priority over tick.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is written with <= so every flop samples pre-edge values.
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != COUNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Traffic-light phase scheduler: main -> side -> turn rotation with demand
// skipping, optional pedestrian WALK, and peak/off-peak green lengths.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int G_MAIN_PEAK = DEF_G_MAIN_PEAK,
    parameter int G_MAIN_OFF  = DEF_G_MAIN_OFF,
    parameter int G_SIDE_PEAK = DEF_G_SIDE_PEAK,
    parameter int G_SIDE_OFF  = DEF_G_SIDE_OFF,
    parameter int G_TURN_PEAK = DEF_G_TURN_PEAK,
    parameter int G_TURN_OFF  = DEF_G_TURN_OFF,
    parameter int Y_TIME      = DEF_Y_TIME,
    parameter int AR_TIME     = DEF_AR_TIME,
    parameter int WALK_TIME   = DEF_WALK_TIME
)
(
    input  logic                  clk,
    input  logic                  reset,
    tlc_phase_scheduler_if.slave  bus
);

    localparam logic [LEN_W-1:0] L_MAIN_PEAK = LEN_W'(G_MAIN_PEAK);
    localparam logic [LEN_W-1:0] L_MAIN_OFF  = LEN_W'(G_MAIN_OFF);
    localparam logic [LEN_W-1:0] L_SIDE_PEAK = LEN_W'(G_SIDE_PEAK);
    localparam logic [LEN_W-1:0] L_SIDE_OFF  = LEN_W'(G_SIDE_OFF);
    localparam logic [LEN_W-1:0] L_TURN_PEAK = LEN_W'(G_TURN_PEAK);
    localparam logic [LEN_W-1:0] L_TURN_OFF  = LEN_W'(G_TURN_OFF);
    localparam logic [LEN_W-1:0] L_YELLOW    = LEN_W'(Y_TIME);
    localparam logic [LEN_W-1:0] L_ALLRED    = LEN_W'(AR_TIME);
    localparam logic [LEN_W-1:0] L_WALK      = LEN_W'(WALK_TIME);

    // Green length of an approach for the given traffic mode.
    function automatic logic [LEN_W-1:0] green_len_for(input phase_t p, input logic pk);
        logic [LEN_W-1:0] len;
        unique case (p)
            PHASE_SIDE: len = pk ? L_SIDE_PEAK : L_SIDE_OFF;
            PHASE_TURN: len = pk ? L_TURN_PEAK : L_TURN_OFF;
            default:    len = pk ? L_MAIN_PEAK : L_MAIN_OFF;
        endcase
        return len;
    endfunction

    state_t             state_q, state_nxt;
    phase_t             phase_q, phase_nxt;
    logic [LEN_W-1:0]   glen_q;
    logic [LEN_W-1:0]   cur_len;
    logic               fresh_q;
    logic               ped_lat_q;
    logic               restart;
    logic               timer_clear;
    logic               walk_entry;
    logic               green_entry;
    logic               side_ok;
    logic               turn_ok;
    logic               main_demand;
    logic [TIMER_W-1:0] timer_count;

    light_t tl_main, tl_side, tl_turn, active_light;
    logic   ped_walk_d;

    tlc_tick_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (bus.tick),
        .count (timer_count)
    );

    assign side_ok     = bus.sensor1 | bus.peak;
    assign turn_ok     = bus.sensor2 | bus.peak;
    assign main_demand = side_ok | turn_ok | ped_lat_q;

    // The first GREEN cycle samples peak; afterwards the latched length holds.
    assign cur_len = fresh_q ? green_len_for(phase_q, bus.peak) : glen_q;

    // Next-state logic: interval expiry, phase rotation with skipping, WALK insertion.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt = state_q;
        phase_nxt = phase_q;
        restart   = 1'b0;
        unique case (state_q)
            ST_GREEN: begin
                if (bus.tick && interval_done(timer_count, cur_len)) begin
                    if ((phase_q != PHASE_MAIN) || main_demand) begin
                        state_nxt = ST_YELLOW;
                    end else begin
                        restart = 1'b1;
                    end
                end
            end
            ST_YELLOW: begin
                if (bus.tick && interval_done(timer_count, L_YELLOW)) begin
                    state_nxt = ST_ALLRED;
                end
            end
            ST_ALLRED: begin
                if (bus.tick && interval_done(timer_count, L_ALLRED)) begin
                    state_nxt = ST_GREEN;
                    phase_nxt = PHASE_MAIN;
                    unique case (phase_q)
                        PHASE_MAIN: begin
                            if (side_ok) begin
                                phase_nxt = PHASE_SIDE;
                            end else if (turn_ok) begin
                                phase_nxt = PHASE_TURN;
                            end else if (ped_lat_q) begin
                                state_nxt = ST_WALK;
                                phase_nxt = PHASE_PED;
                            end
                        end
                        PHASE_SIDE: begin
                            if (turn_ok) begin
                                phase_nxt = PHASE_TURN;
                            end else if (ped_lat_q) begin
                                state_nxt = ST_WALK;
                                phase_nxt = PHASE_PED;
                            end
                        end
                        default: begin
                            if (ped_lat_q) begin
                                state_nxt = ST_WALK;
                                phase_nxt = PHASE_PED;
                            end
                        end
                    endcase
                end
            end
            default: begin
                if (bus.tick && interval_done(timer_count, L_WALK)) begin
                    state_nxt = ST_GREEN;
                    phase_nxt = PHASE_MAIN;
                end
            end
        endcase
    end

    assign timer_clear = (state_nxt != state_q) || restart;
    assign walk_entry  = (state_nxt == ST_WALK) && (state_q != ST_WALK);
    assign green_entry = (state_nxt == ST_GREEN) && ((state_q != ST_GREEN) || restart);

    // State, phase, green-length latch and pedestrian request latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_GREEN;
            phase_q   <= PHASE_MAIN;
            glen_q    <= L_MAIN_OFF;
            fresh_q   <= 1'b1;
            ped_lat_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            phase_q   <= phase_nxt;
            glen_q    <= cur_len;
            fresh_q   <= green_entry;
            // A new press wins over the clear caused by entering WALK.
            ped_lat_q <= bus.ped_req | (ped_lat_q & ~walk_entry);
        end
    end

    // Light decode from registered state only, so reset reaches the lights at once.
    always_comb begin
        tl_main      = LIGHT_RED;
        tl_side      = LIGHT_RED;
        tl_turn      = LIGHT_RED;
        ped_walk_d   = 1'b0;
        active_light = LIGHT_RED;
        unique case (state_q)
            ST_GREEN:  active_light = LIGHT_GREEN;
            ST_YELLOW: active_light = LIGHT_YELLOW;
            ST_WALK:   ped_walk_d   = 1'b1;
            default:   active_light = LIGHT_RED;
        endcase
        unique case (phase_q)
            PHASE_MAIN: tl_main = active_light;
            PHASE_SIDE: tl_side = active_light;
            PHASE_TURN: tl_turn = active_light;
            default:    tl_main = LIGHT_RED;
        endcase
    end

    assign bus.TL_main  = tl_main;
    assign bus.TL_side  = tl_side;
    assign bus.TL_turn  = tl_turn;
    assign bus.ped_walk = ped_walk_d;
    assign bus.phase    = phase_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler; expected cycle counts are hand-derived
// from the default durations with tick asserted every cycle.
module tb_tlc_phase_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    tlc_phase_scheduler_if bus ();

    tlc_phase_scheduler dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Lights, walk and phase together.
    task automatic check_out(input string tag, input logic [1:0] m, input logic [1:0] s,
                             input logic [1:0] t, input logic pw, input logic [1:0] ph);
        check({tag, ".main"}, 8'(bus.TL_main), 8'(m));
        check({tag, ".side"}, 8'(bus.TL_side), 8'(s));
        check({tag, ".turn"}, 8'(bus.TL_turn), 8'(t));
        check({tag, ".walk"}, 8'(bus.ped_walk), 8'(pw));
        check({tag, ".phase"}, 8'(bus.phase), 8'(ph));
    endtask

    // Step to the falling edge after rising edge number target since reset release.
    task automatic adv_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset(input logic pk, input logic s1, input logic s2);
        @(negedge clk);
        rst         = 1'b1;
        bus.tick    = 1'b1;
        bus.peak    = pk;
        bus.sensor1 = s1;
        bus.sensor2 = s2;
        bus.ped_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        bus.tick    = 1'b0;
        bus.peak    = 1'b0;
        bus.sensor1 = 1'b0;
        bus.sensor2 = 1'b0;
        bus.ped_req = 1'b0;

        // Off-peak, no demand: main stays green, timer restarts every 16 ticks.
        do_reset(1'b0, 1'b0, 1'b0);
        check_out("rst", 2'd0, 2'd2, 2'd2, 1'b0, 2'd0);
        check("rst.timer", 8'(dut.timer_count), 8'd0);
        for (int n = 1; n <= 40; n++) begin
            adv_to(n);
            check("idle.main", 8'(bus.TL_main), 8'd0);
            if (n == 15) check("idle.timer15", 8'(dut.timer_count), 8'd15);
            if (n == 16) check("idle.timer16", 8'(dut.timer_count), 8'd0);
            if (n == 40) check("idle.timer40", 8'(dut.timer_count), 8'd8);
        end

        // Peak: main 32, yellow 4, all-red 2, side 32, turn 16, back to main.
        do_reset(1'b1, 1'b0, 1'b0);
        adv_to(31);  check_out("pk.n31", 2'd0, 2'd2, 2'd2, 1'b0, 2'd0);
        adv_to(32);  check_out("pk.n32", 2'd1, 2'd2, 2'd2, 1'b0, 2'd0);
        adv_to(35);  check_out("pk.n35", 2'd1, 2'd2, 2'd2, 1'b0, 2'd0);
        adv_to(36);  check_out("pk.n36", 2'd2, 2'd2, 2'd2, 1'b0, 2'd0);
        adv_to(37);  check_out("pk.n37", 2'd2, 2'd2, 2'd2, 1'b0, 2'd0);
        adv_to(38);  check_out("pk.n38", 2'd2, 2'd0, 2'd2, 1'b0, 2'd1);
        adv_to(69);  check_out("pk.n69", 2'd2, 2'd0, 2'd2, 1'b0, 2'd1);
        adv_to(70);  check_out("pk.n70", 2'd2, 2'd1, 2'd2, 1'b0, 2'd1);
        adv_to(74);  check_out("pk.n74", 2'd2, 2'd2, 2'd2, 1'b0, 2'd1);
        adv_to(76);  check_out("pk.n76", 2'd2, 2'd2, 2'd0, 1'b0, 2'd2);
        adv_to(91);  check_out("pk.n91", 2'd2, 2'd2, 2'd0, 1'b0, 2'd2);
        adv_to(92);  check_out("pk.n92", 2'd2, 2'd2, 2'd1, 1'b0, 2'd2);
        adv_to(96);  check_out("pk.n96", 2'd2, 2'd2, 2'd2, 1'b0, 2'd2);
        adv_to(98);  check_out("pk.n98", 2'd0, 2'd2, 2'd2, 1'b0, 2'd0);

        // Off-peak, turn demand only: side skipped, turn gets 8.
        do_reset(1'b0, 1'b0, 1'b1);
        for (int n = 1; n <= 36; n++) begin
            adv_to(n);
            check("turn.side_red", 8'(bus.TL_side), 8'd2);
            if (n == 15) check_out("turn.n15", 2'd0, 2'd2, 2'd2, 1'b0, 2'd0);
            if (n == 16) check_out("turn.n16", 2'd1, 2'd2, 2'd2, 1'b0, 2'd0);
            if (n == 20) check_out("turn.n20", 2'd2, 2'd2, 2'd2, 1'b0, 2'd0);
            if (n == 22) check_out("turn.n22", 2'd2, 2'd2, 2'd0, 1'b0, 2'd2);
            if (n == 29) check_out("turn.n29", 2'd2, 2'd2, 2'd0, 1'b0, 2'd2);
            if (n == 30) check_out("turn.n30", 2'd2, 2'd2, 2'd1, 1'b0, 2'd2);
            if (n == 34) check_out("turn.n34", 2'd2, 2'd2, 2'd2, 1'b0, 2'd2);
            if (n == 36) check_out("turn.n36", 2'd0, 2'd2, 2'd2, 1'b0, 2'd0);
        end

        // Asynchronous reset during turn yellow, checked before the next rising edge.
        do_reset(1'b0, 1'b0, 1'b1);
        adv_to(31);
        check_out("arst.pre", 2'd2, 2'd2, 2'd1, 1'b0, 2'd2);
        #1 rst = 1'b1;
        #1;
        check_out("arst.post", 2'd0, 2'd2, 2'd2, 1'b0, 2'd0);

        // Peak with a one-cycle press during side green: WALK after the turn slot.
        do_reset(1'b1, 1'b0, 1'b0);
        adv_to(40);
        bus.ped_req = 1'b1;
        adv_to(41);
        bus.ped_req = 1'b0;
        adv_to(69);  check_out("ped.n69", 2'd2, 2'd0, 2'd2, 1'b0, 2'd1);
        adv_to(97);  check_out("ped.n97", 2'd2, 2'd2, 2'd2, 1'b0, 2'd2);
        adv_to(98);  check_out("ped.n98", 2'd2, 2'd2, 2'd2, 1'b1, 2'd3);
        adv_to(105); check_out("ped.n105", 2'd2, 2'd2, 2'd2, 1'b1, 2'd3);
        adv_to(106); check_out("ped.n106", 2'd0, 2'd2, 2'd2, 1'b0, 2'd0);

        // Off-peak press only: side and turn skipped, WALK follows main's all-red,
        // and once served main rests green again.
        do_reset(1'b0, 1'b0, 1'b0);
        adv_to(3);
        bus.ped_req = 1'b1;
        adv_to(4);
        bus.ped_req = 1'b0;
        adv_to(16);  check_out("pw.n16", 2'd1, 2'd2, 2'd2, 1'b0, 2'd0);
        adv_to(21);  check_out("pw.n21", 2'd2, 2'd2, 2'd2, 1'b0, 2'd0);
        adv_to(22);  check_out("pw.n22", 2'd2, 2'd2, 2'd2, 1'b1, 2'd3);
        adv_to(29);  check_out("pw.n29", 2'd2, 2'd2, 2'd2, 1'b1, 2'd3);
        adv_to(30);  check_out("pw.n30", 2'd0, 2'd2, 2'd2, 1'b0, 2'd0);
        adv_to(45);  check("pw.timer45", 8'(dut.timer_count), 8'd15);
        adv_to(46);  check_out("pw.n46", 2'd0, 2'd2, 2'd2, 1'b0, 2'd0);
        check("pw.timer46", 8'(dut.timer_count), 8'd0);

        // Peak raised at main green tick 5: this green stays 16, next main green is 32.
        do_reset(1'b0, 1'b0, 1'b0);
        adv_to(5);
        bus.peak = 1'b1;
        adv_to(15);  check_out("mid.n15", 2'd0, 2'd2, 2'd2, 1'b0, 2'd0);
        adv_to(16);  check_out("mid.n16", 2'd1, 2'd2, 2'd2, 1'b0, 2'd0);
        adv_to(22);  check_out("mid.n22", 2'd2, 2'd0, 2'd2, 1'b0, 2'd1);
        adv_to(82);  check_out("mid.n82", 2'd0, 2'd2, 2'd2, 1'b0, 2'd0);
        adv_to(113); check_out("mid.n113", 2'd0, 2'd2, 2'd2, 1'b0, 2'd0);
        adv_to(114); check_out("mid.n114", 2'd1, 2'd2, 2'd2, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlc_phase_scheduler.md
TLC_PHASE_SCHEDULER -- requirements
Module: tlc_phase_scheduler

Interface
REQ-001 Parameter G_MAIN_PEAK, default 32, main-road green length in ticks during peak.
REQ-002 Parameter G_MAIN_OFF, default 16, main-road green length in ticks off-peak.
REQ-003 Parameter G_SIDE_PEAK / G_SIDE_OFF, default 32 / 16, side-road green lengths in ticks.
REQ-004 Parameter G_TURN_PEAK / G_TURN_OFF, default 16 / 8, turn-phase green lengths in ticks.
REQ-005 Parameters Y_TIME, AR_TIME and WALK_TIME, defaults 4, 2 and 8, giving yellow, all-red and pedestrian-walk lengths in ticks.
REQ-006 clk  in  1  sole clock; all state changes occur on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 tick  in  1  one-cycle timing enable; all durations are counted in ticks.
REQ-009 peak  in  1  peak-traffic mode.
REQ-010 sensor1  in  1  side-road vehicle demand (level).
REQ-011 sensor2  in  1  turn-lane vehicle demand (level).
REQ-012 ped_req  in  1  pedestrian button (pulse, any width).
REQ-013 TL_main, TL_side, TL_turn  out  2 each  light codes: 0 green, 1 yellow, 2 red; 3 never driven.
REQ-014 ped_walk  out  1  pedestrian walk signal.
REQ-015 phase  out  2  active phase: 0 main, 1 side, 2 turn, 3 pedestrian.

Function
REQ-016 The FSM SHALL have four states: GREEN, YELLOW, ALLRED and WALK; the phase register selects which approach GREEN and YELLOW apply to.
REQ-017 A 6-bit timer SHALL increment only on tick, reset to 0 on every state change, and saturate at 63.
REQ-018 GREEN SHALL exit to YELLOW on the tick where timer+1 equals the green length; the length is latched from peak at GREEN entry, and a change of peak mid-green has no effect.
REQ-019 YELLOW SHALL exit to ALLRED after Y_TIME ticks, and ALLRED SHALL exit after AR_TIME ticks.
REQ-020 At ALLRED exit the next phase SHALL be chosen in order main->side->turn->main; side is served only if sensor1 or peak, and turn only if sensor2 or peak; unserved phases are skipped.
REQ-021 A pending pedestrian request SHALL insert WALK between the ALLRED that follows the turn slot (served or skipped) and main GREEN.
REQ-022 WALK SHALL last WALK_TIME ticks with all lights red and ped_walk=1, then go directly to main GREEN.
REQ-023 If main green expires with no side, turn or pedestrian demand, main SHALL stay GREEN and the timer SHALL restart at 0.
REQ-024 The ped_req latch SHALL set on any cycle where ped_req=1 and clear on WALK entry; a request during WALK re-sets the latch for the next cycle.
REQ-025 If the latch sets and clears in the same cycle, the set SHALL win.
REQ-026 Only the active phase's light SHALL be non-red; in ALLRED and WALK all three lights SHALL be 2.
REQ-027 Outputs SHALL be registered, or decoded from registered state only, and SHALL be glitch-free.

Reset
REQ-028 On reset the block SHALL enter GREEN with phase=0 and timer=0, clear the ped latch, and drive TL_main=0, TL_side=2, TL_turn=2, ped_walk=0, phase=0.
REQ-029 Reset asserted mid-operation SHALL force this state immediately, regardless of clk.

Structure
REQ-030 The light codes, phase codes, state enum and default durations SHALL live in shared package tlc_pkg.
REQ-031 The timer SHALL be sub-module tlc_tick_timer (clear, tick, count output); the FSM and decode stay in the top module.

Verification
REQ-032 Reset, then tick every cycle, peak=0, no demand, for 40 ticks -> TL_main stays 0 and timer wraps to 0 at 16.
REQ-033 peak=1, tick every cycle -> TL_main is green for 32 ticks, yellow 4, all-red 2; side green 32; turn green 16; then back to main.
REQ-034 peak=0, sensor2=1, sensor1=0 -> main 16, yellow 4, all-red 2, turn green 8, and side is never green.
REQ-035 A 1-cycle ped_req during side green -> WALK for 8 ticks (ped_walk=1, all lights 2) after the turn-slot all-red, then main green.
REQ-036 Reset asserted during turn YELLOW, between clock edges -> outputs become the reset values before the next clk edge.
REQ-037 peak toggled from 0 to 1 at main green tick 5 -> that green still ends at 16; the next main green lasts 32.
